// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer.
// Stage-register control codes and controller state.
package hazard_pkg;

  localparam logic [1:0] FS_RUN   = 2'b00;
  localparam logic [1:0] FS_STALL = 2'b01;
  localparam logic [1:0] FS_FLUSH = 2'b10;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_MEM_WAIT,
    HZ_REDIRECT
  } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for stall/flush perf monitoring.
// Sticks at all-ones; cleared only by the synchronous clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clear_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use,
// memory wait handshakes and MEM-stage branch redirects.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           id_rs1_addr,
  input  logic [4:0]           id_rs2_addr,
  input  logic [4:0]           ex_rd_addr,
  input  logic                 ex_MemRead,
  input  logic                 if_req,
  input  logic                 if_ack,
  input  logic                 mem_req,
  input  logic                 mem_ack,
  input  logic                 branch_taken,
  output logic                 pc_stall,
  output logic                 pc_load,
  output logic [1:0]           ifid_fs,
  output logic [1:0]           idex_fs,
  output logic [1:0]           exmem_fs,
  output logic [1:0]           memwb_fs,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  hz_state_t state_q, state_d;
  logic      dwait, fwait, lu;
  logic      flush_any;

  assign dwait = mem_req & ~mem_ack;
  assign fwait = if_req & ~if_ack;
  assign lu    = ex_MemRead & (ex_rd_addr != 5'd0) &
                 ((ex_rd_addr == id_rs1_addr) |
                  (ex_rd_addr == id_rs2_addr));

  always_comb begin
    state_d  = state_q;
    pc_stall = 1'b0;
    pc_load  = 1'b0;
    ifid_fs  = FS_RUN;
    idex_fs  = FS_RUN;
    exmem_fs = FS_RUN;
    memwb_fs = FS_RUN;
    if (reset) begin
      state_d = HZ_RUN;
    end else if (dwait) begin
      pc_stall = 1'b1;
      ifid_fs  = FS_STALL;
      idex_fs  = FS_STALL;
      exmem_fs = FS_STALL;
      memwb_fs = FS_FLUSH;
      // A pending redirect survives a data wait.
      if (state_q != HZ_REDIRECT) state_d = HZ_MEM_WAIT;
    end else if (state_q == HZ_REDIRECT) begin
      ifid_fs = FS_FLUSH;
      if (if_ack) begin
        pc_load = 1'b1;
        state_d = HZ_RUN;
      end else begin
        pc_stall = 1'b1;
      end
    end else begin
      state_d = HZ_RUN;
      if (branch_taken) begin
        ifid_fs  = FS_FLUSH;
        idex_fs  = FS_FLUSH;
        exmem_fs = FS_FLUSH;
        if (fwait) begin
          pc_stall = 1'b1;
          state_d  = HZ_REDIRECT;
        end else begin
          pc_load = 1'b1;
        end
      end else if (lu) begin
        pc_stall = 1'b1;
        ifid_fs  = FS_STALL;
        idex_fs  = FS_FLUSH;
      end else if (fwait) begin
        pc_stall = 1'b1;
        ifid_fs  = FS_FLUSH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= HZ_RUN;
    else       state_q <= state_d;
  end

  assign flush_any = ifid_fs[1] | idex_fs[1] |
                     exmem_fs[1] | memwb_fs[1];

  sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
    .clk     (clk),
    .clear_i (reset),
    .inc_i   (pc_stall),
    .cnt_o   (stall_cnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_flush_cnt (
    .clk     (clk),
    .clear_i (reset),
    .inc_i   (flush_any),
    .cnt_o   (flush_cnt)
  );

  // A frozen or redirecting MEM stage cannot resolve a branch.
  ap_branch_legal: assert property (
    @(posedge clk) disable iff (reset)
    branch_taken |-> (state_q == HZ_RUN && !dwait));

  ap_pc_excl: assert property (
    @(posedge clk) !(pc_load && pc_stall));

  ap_fs_legal: assert property (
    @(posedge clk) (ifid_fs != 2'b11) && (idex_fs != 2'b11) &&
    (exmem_fs != 2'b11) && (memwb_fs != 2'b11));

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table
// plus hand sequences for waits, redirects and saturation.
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  localparam int CW = 32;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic          ex_MemRead, if_req, if_ack;
  logic          mem_req, mem_ack, branch_taken;
  logic          pc_stall, pc_load;
  logic [1:0]    ifid_fs, idex_fs, exmem_fs, memwb_fs;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .ex_rd_addr   (ex_rd_addr),
    .ex_MemRead   (ex_MemRead),
    .if_req       (if_req),
    .if_ack       (if_ack),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .branch_taken (branch_taken),
    .pc_stall     (pc_stall),
    .pc_load      (pc_load),
    .ifid_fs      (ifid_fs),
    .idex_fs      (idex_fs),
    .exmem_fs     (exmem_fs),
    .memwb_fs     (memwb_fs),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       mr, ifr, ifa, mrq, mak, br;
    logic       ps, pl;
    logic [1:0] ifid, idex, exmem, memwb;
  } vec_t;

  vec_t          sb[$];
  vec_t          tbl[12];
  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] stall_m = '0;
  logic [CW-1:0] flush_m = '0;

  function automatic vec_t v0();
    vec_t v;
    v = '{1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0,
          1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    vec_t e;
    logic [9:0] got, exp;
    reset        = v.rst;
    id_rs1_addr  = v.rs1;
    id_rs2_addr  = v.rs2;
    ex_rd_addr   = v.rd;
    ex_MemRead   = v.mr;
    if_req       = v.ifr;
    if_ack       = v.ifa;
    mem_req      = v.mrq;
    mem_ack      = v.mak;
    branch_taken = v.br;
    sb.push_back(v);
    @(negedge clk);
    e   = sb.pop_front();
    got = {pc_stall, pc_load, ifid_fs, idex_fs, exmem_fs, memwb_fs};
    exp = {e.ps, e.pl, e.ifid, e.idex, e.exmem, e.memwb};
    chk({nm, "/outs"}, 64'(got), 64'(exp));
    if (e.rst) begin
      stall_m = '0;
      flush_m = '0;
    end else begin
      if (e.ps && stall_m != CMAX) stall_m++;
      if ((e.ifid[1] | e.idex[1] | e.exmem[1] | e.memwb[1]) &&
          flush_m != CMAX) flush_m++;
    end
    @(posedge clk);
    #1;
    chk({nm, "/stall_cnt"}, 64'(stall_cnt), 64'(stall_m));
    chk({nm, "/flush_cnt"}, 64'(flush_cnt), 64'(flush_m));
  endtask

  vec_t v;

  initial begin
    tbl[0]  = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{0, 1, 5, 5, 1, 0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'b00};
    tbl[2]  = '{0, 7, 2, 7, 1, 0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'b00};
    tbl[3]  = '{0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[4]  = '{0, 5, 2, 5, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[5]  = '{0, 1, 2, 3, 0, 1, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b00, 2'b00};
    tbl[6]  = '{0, 4, 2, 4, 1, 1, 0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'b00};
    tbl[7]  = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 1, 0, 1, 2'b10, 2'b10, 2'b10, 2'b00};
    tbl[8]  = '{0, 1, 2, 3, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[9]  = '{0, 1, 2, 3, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[10] = '{0, 1, 2, 3, 0, 1, 1, 0, 0, 1, 0, 1, 2'b10, 2'b10, 2'b10, 2'b00};
    tbl[11] = '{0, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00};

    reset = 1'b1;
    {id_rs1_addr, id_rs2_addr, ex_rd_addr} = '0;
    {ex_MemRead, if_req, if_ack} = '0;
    {mem_req, mem_ack, branch_taken} = '0;
    repeat (2) @(posedge clk);
    #1;
    v = v0(); v.rst = 1; v.ifr = 1;
    apply(v, "reset");

    for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // data wait: three held cycles, load-use masked, then ack
    for (int i = 0; i < 3; i++) begin
      v = v0(); v.mrq = 1; v.ps = 1;
      v.ifid = 2'b01; v.idex = 2'b01; v.exmem = 2'b01; v.memwb = 2'b10;
      if (i == 1) begin v.mr = 1; v.rd = 2; end
      apply(v, $sformatf("dwait%0d", i));
      chk("dwait/state", 64'(dut.state_q), 64'(HZ_MEM_WAIT));
    end
    v = v0(); v.mrq = 1; v.mak = 1;
    apply(v, "dwait_ack");
    chk("dwait_ack/state", 64'(dut.state_q), 64'(HZ_RUN));

    // branch during outstanding fetch -> redirect
    v = v0(); v.br = 1; v.ifr = 1; v.ps = 1;
    v.ifid = 2'b10; v.idex = 2'b10; v.exmem = 2'b10;
    apply(v, "redir_br");
    chk("redir/state", 64'(dut.state_q), 64'(HZ_REDIRECT));
    for (int i = 0; i < 2; i++) begin
      v = v0(); v.ifr = 1; v.ps = 1; v.ifid = 2'b10;
      if (i == 0) begin v.mr = 1; v.rd = 1; end
      apply(v, $sformatf("redir_wait%0d", i));
    end
    v = v0(); v.ifr = 1; v.ifa = 1; v.pl = 1; v.ifid = 2'b10;
    apply(v, "redir_ack");
    apply(v0(), "post_redir");

    // saturation of stall counter
    force dut.u_stall_cnt.cnt_q = CMAX - 1;
    #1;
    release dut.u_stall_cnt.cnt_q;
    stall_m = CMAX - 1;
    for (int i = 0; i < 3; i++) begin
      v = v0(); v.ifr = 1; v.ps = 1; v.ifid = 2'b10;
      apply(v, $sformatf("sat%0d", i));
    end

    // reset while redirecting
    v = v0(); v.br = 1; v.ifr = 1; v.ps = 1;
    v.ifid = 2'b10; v.idex = 2'b10; v.exmem = 2'b10;
    apply(v, "rst_redir_br");
    v = v0(); v.rst = 1; v.ifr = 1;
    apply(v, "rst_in_redir");
    chk("rst_redir/state", 64'(dut.state_q), 64'(HZ_RUN));
    v = v0(); v.ifr = 1; v.ifa = 1;
    apply(v, "rst_redir_lost");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
